// File: rtl/note_player_if.sv
// Read-port bundle between note_player and the note RAM: registered address
// out, word returned one cycle after the address is registered.
interface note_player_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_q;

    modport master (output ram_addr, input ram_q);
    modport slave  (input ram_addr, output ram_q);
endinterface

// File: rtl/note_player.sv
// Steps through the note RAM one word per beat tick, decodes six string voices
// and mixes their square waves. Optional NOTE_PLAYER_ARTIC_EN mutes after each latch.
module note_player #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int ADDR_W       = 6,
    parameter int AMP          = 4096,
    parameter int ARTIC_CYCLES = 10000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                play,
    input  logic                tick,
    note_player_if.master       ram,
    output logic [31:0]         note_cur,
    output logic [5:0]          voice_active,
    output logic signed [15:0]  audio_out,
    output logic                wrapped
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RD1  = 2'd2;
    localparam logic [1:0] ST_RD2  = 2'd3;

    // Semitone offset of each open string above low E, 5 bits per string.
    localparam logic [29:0] OFF_TAB = {5'd24, 5'd19, 5'd15, 5'd10, 5'd5, 5'd0};
    localparam logic signed [18:0] AMP_S = 19'(AMP);

    // Half period in clk cycles of semitone k above 82.4069 Hz, rounded.
    function automatic int hp_calc(input int k);
        real f;
        f = 82.4069 * (2.0 ** (real'(k) / 12.0));
        return int'(real'(CLK_HZ) / (2.0 * f));
    endfunction

    logic [1:0]        state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              clr;
    logic              latch;

    assign clr   = reset || !play;
    assign latch = (state_reg == ST_RD2);
    assign ram.ram_addr = addr_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            note_cur  <= '0;
            wrapped   <= 1'b0;
        end else begin
            wrapped <= 1'b0;
            case (state_reg)
                ST_IDLE: state_reg <= ST_WAIT;
                ST_WAIT: if (tick) state_reg <= ST_RD1;
                ST_RD1:  state_reg <= ST_RD2;
                ST_RD2: begin
                    note_cur  <= ram.ram_q;
                    addr_reg  <= addr_reg + 1'b1;
                    wrapped   <= &addr_reg;
                    state_reg <= ST_WAIT;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    logic [31:0] hp_tab [32];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_hp
            localparam int HP = hp_calc(gi);
            assign hp_tab[gi] = HP;
        end
    endgenerate

    logic signed [18:0] contrib [6];

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_voice
            logic        new_act;
            logic [2:0]  new_fret;
            logic [4:0]  new_k;
            logic        act_reg;
            logic [4:0]  k_reg;
            logic [31:0] cnt_reg;
            logic        sq_reg;

            // Ascending scan so the highest set fret overrides lower ones.
            always_comb begin
                new_act  = 1'b0;
                new_fret = 3'd0;
                for (int f = 0; f < 5; f++) begin
                    if (ram.ram_q[6*f+gi]) begin
                        new_act  = 1'b1;
                        new_fret = 3'(f);
                    end
                end
                new_k = OFF_TAB[5*gi +: 5] + 5'(new_fret);
            end

            // A held pitch keeps its counter and phase across latches.
            always_ff @(posedge clk) begin
                if (clr) begin
                    act_reg <= 1'b0;
                    k_reg   <= '0;
                    cnt_reg <= '0;
                    sq_reg  <= 1'b0;
                end else if (latch && new_act && (!act_reg || k_reg != new_k)) begin
                    act_reg <= 1'b1;
                    k_reg   <= new_k;
                    cnt_reg <= hp_tab[new_k] - 32'd1;
                    sq_reg  <= 1'b1;
                end else begin
                    if (latch) act_reg <= new_act;
                    if (act_reg) begin
                        if (cnt_reg == '0) begin
                            cnt_reg <= hp_tab[k_reg] - 32'd1;
                            sq_reg  <= ~sq_reg;
                        end else begin
                            cnt_reg <= cnt_reg - 32'd1;
                        end
                    end
                end
            end

            assign voice_active[gi] = act_reg;
            assign contrib[gi] = act_reg ? (sq_reg ? AMP_S : -AMP_S) : '0;
        end
    endgenerate

    logic signed [18:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < 6; i++) sum = sum + contrib[i];
    end

`ifdef NOTE_PLAYER_ARTIC_EN
    logic [31:0] artic_reg;

    // The mute window covers the latch cycle itself, hence the -1 preload.
    always_ff @(posedge clk) begin
        if (clr) begin
            audio_out <= '0;
            artic_reg <= '0;
        end else if (latch) begin
            audio_out <= '0;
            artic_reg <= 32'(ARTIC_CYCLES - 1);
        end else if (artic_reg != '0) begin
            audio_out <= '0;
            artic_reg <= artic_reg - 32'd1;
        end else begin
            audio_out <= sum[15:0];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (clr) audio_out <= '0;
        else     audio_out <= sum[15:0];
    end
`endif

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: expected latches are queued at each tick
// and compared, with a per-cycle phase model of the audio mix.
module tb_note_player;
    localparam int CLK_HZ = 50_000;
    localparam int ADDR_W = 6;
    localparam int AMP    = 4096;

    logic               clk;
    logic               reset;
    logic               play;
    logic               tick;
    logic [31:0]        note_cur;
    logic [5:0]         voice_active;
    logic signed [15:0] audio_out;
    logic               wrapped;

    note_player_if #(.ADDR_W(ADDR_W)) bus ();

    note_player #(.CLK_HZ(CLK_HZ), .ADDR_W(ADDR_W), .AMP(AMP), .ARTIC_CYCLES(10000)) dut (
        .clk(clk), .reset(reset), .play(play), .tick(tick), .ram(bus.master),
        .note_cur(note_cur), .voice_active(voice_active), .audio_out(audio_out),
        .wrapped(wrapped)
    );

    logic [31:0] mem [64];
    always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [31:0] word;
        logic        wrap;
        logic [5:0]  addr;
    } exp_t;
    exp_t sb[$];

    logic [5:0] drv_addr = '0;
    bit         mon_en = 1'b0;

    int OFFS [6] = '{0, 5, 10, 15, 19, 24};

    function automatic int hp_of(input int k);
        real f;
        f = 82.4069 * (2.0 ** (real'(k) / 12.0));
        return int'(real'(CLK_HZ) / (2.0 * f));
    endfunction

    // Reference model state (owned by the monitor).
    logic [31:0] m_note;
    logic [5:0]  m_addr;
    logic        m_wrap;
    bit          m_act [6];
    int          m_k [6];
    int          m_t0 [6];
    int          m_hp [6];
    int          exp_audio;
    exp_t        e;
    bit          na;
    int          nk;

    always @(negedge clk) begin
        if (!mon_en) begin
            m_note = '0;
            m_addr = '0;
            for (int s = 0; s < 6; s++) m_act[s] = 1'b0;
        end else begin
            // audio in this cycle reflects the voices of the previous cycle
            exp_audio = 0;
            for (int s = 0; s < 6; s++)
                if (m_act[s])
                    exp_audio += ((((cyc - 1 - m_t0[s]) / m_hp[s]) % 2) == 0) ? AMP : -AMP;
            m_wrap = 1'b0;
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL latch_timeout cyc=%0d: expected latch at %0d never observed", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                m_note = e.word;
                m_addr = e.addr;
                m_wrap = e.wrap;
                for (int s = 0; s < 6; s++) begin
                    na = 1'b0; nk = 0;
                    for (int f = 4; f >= 0; f--)
                        if (!na && e.word[6*f+s]) begin na = 1'b1; nk = OFFS[s] + f; end
                    if (na && (!m_act[s] || m_k[s] != nk)) begin
                        m_t0[s] = cyc; m_k[s] = nk; m_hp[s] = hp_of(nk);
                    end
                    m_act[s] = na;
                end
            end
            checks++;
            if (note_cur !== m_note) begin
                errors++; $display("FAIL note_cur cyc=%0d got=%h exp=%h", cyc, note_cur, m_note);
            end
            checks++;
            if (voice_active !== {m_act[5], m_act[4], m_act[3], m_act[2], m_act[1], m_act[0]}) begin
                errors++; $display("FAIL voice_active cyc=%0d got=%b exp=%b", cyc, voice_active,
                                   {m_act[5], m_act[4], m_act[3], m_act[2], m_act[1], m_act[0]});
            end
            checks++;
            if (bus.ram_addr !== m_addr) begin
                errors++; $display("FAIL ram_addr cyc=%0d got=%0d exp=%0d", cyc, bus.ram_addr, m_addr);
            end
            checks++;
            if (wrapped !== m_wrap) begin
                errors++; $display("FAIL wrapped cyc=%0d got=%b exp=%b", cyc, wrapped, m_wrap);
            end
            checks++;
            if (audio_out !== 16'(exp_audio)) begin
                errors++; $display("FAIL audio_out cyc=%0d got=%0d exp=%0d", cyc, audio_out, exp_audio);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step(1);
    endtask

    // One-cycle tick; an accepted tick queues the word the DUT must latch 3 cycles later.
    task automatic do_tick(input bit acc);
        exp_t x;
        tick = 1'b1;
        if (acc) begin
            x.cyc  = cyc + 3;
            x.word = mem[drv_addr];
            x.wrap = (drv_addr == 6'd63);
            drv_addr = drv_addr + 6'd1;
            x.addr = drv_addr;
            sb.push_back(x);
            $display("tick cyc=%0d word=%h latch_at=%0d", cyc, x.word, x.cyc);
        end
        step(1);
        tick = 1'b0;
    endtask

    task automatic restart_play();
        mon_en = 1'b0;
        play = 1'b0;
        step(2);
        drv_addr = '0;
        play = 1'b1;
        mon_en = 1'b1;
        step(2);
    endtask

    task automatic test_reset();
        reset = 1'b1; play = 1'b0; tick = 1'b0;
        step(3);
        checks++;
        if ({note_cur, voice_active, audio_out, wrapped, bus.ram_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state note=%h va=%b audio=%0d wr=%b addr=%0d exp all 0",
                     note_cur, voice_active, audio_out, wrapped, bus.ram_addr);
        end
        reset = 1'b0;
        step(2);
        checks++;
        if ({note_cur, voice_active, audio_out, bus.ram_addr} !== '0) begin
            errors++;
            $display("FAIL idle_state note=%h va=%b audio=%0d addr=%0d exp all 0",
                     note_cur, voice_active, audio_out, bus.ram_addr);
        end
    endtask

    task automatic test_single_note();
        int l; int hp;
        mem[0] = 32'h0000_0002;
        restart_play();
        hp = hp_of(5);
        l = cyc + 3;
        do_tick(1);
        step_to(l);
        checks++;
        if (note_cur !== 32'h2 || voice_active !== 6'b000010) begin
            errors++; $display("FAIL single_latch note=%h va=%b exp note=00000002 va=000010", note_cur, voice_active);
        end
        step_to(l + 1);
        checks++;
        if (audio_out !== 16'sd4096) begin
            errors++; $display("FAIL single_first_audio got=%0d exp=4096", audio_out);
        end
        step_to(l + 1 + hp);
        checks++;
        if (audio_out !== -16'sd4096) begin
            errors++; $display("FAIL single_half_period got=%0d exp=-4096", audio_out);
        end
        step_to(l + 1 + 2 * hp);
        checks++;
        if (audio_out !== 16'sd4096) begin
            errors++; $display("FAIL single_full_period got=%0d exp=4096", audio_out);
        end
    endtask

    task automatic test_fret_priority();
        int l;
        mem[1] = (32'h1 << 13) | (32'h1 << 25);
        mem[2] = 32'h1 << 20;
        l = cyc + 3;
        do_tick(1);
        step(300);
        l = cyc + 3;
        do_tick(1);
        step_to(l);
        checks++;
        if (voice_active !== 6'b000100) begin
            errors++; $display("FAIL dstring_voice got=%b exp=000100", voice_active);
        end
        step(350);
    endtask

    task automatic test_held_note();
        int l1; int hp;
        mem[0] = 32'h2; mem[1] = 32'h2;
        restart_play();
        hp = hp_of(5);
        l1 = cyc + 3;
        do_tick(1);
        step(100);
        do_tick(1);
        step_to(l1 + 1 + hp);
        checks++;
        if (audio_out !== -16'sd4096) begin
            errors++; $display("FAIL held_phase got=%0d exp=-4096", audio_out);
        end
        step(200);
    endtask

    task automatic test_all_open();
        int l;
        mem[0] = 32'h3F;
        restart_play();
        l = cyc + 3;
        do_tick(1);
        step_to(l + 1);
        checks++;
        if (voice_active !== 6'h3F || audio_out !== 16'sd24576) begin
            errors++; $display("FAIL all_open va=%h audio=%0d exp va=3f audio=24576", voice_active, audio_out);
        end
        step(400);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        restart_play();
        for (int i = 0; i < 3; i++) begin
            do_tick(1);
            step(2);
        end
        do_tick(1);
        do_tick(0);
        step(1);
        do_tick(1);
        step(1);
        do_tick(0);
        do_tick(1);
        step(300);
    endtask

    task automatic test_wrap();
        int wrap_cnt = 0;
        int l = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
        restart_play();
        for (int i = 0; i < 65; i++) begin
            l = cyc + 3;
            do_tick(1);
            for (int j = 0; j < 3; j++) begin
                step(1);
                if (wrapped === 1'b1) wrap_cnt++;
            end
            if (i == 63) begin
                checks++;
                if (bus.ram_addr !== '0) begin
                    errors++; $display("FAIL wrap_addr got=%0d exp=0", bus.ram_addr);
                end
            end
        end
        checks++;
        if (wrap_cnt != 1) begin
            errors++; $display("FAIL wrap_pulse_count got=%0d exp=1", wrap_cnt);
        end
        checks++;
        if (note_cur !== mem[0]) begin
            errors++; $display("FAIL wrap_replay got=%h exp=%h", note_cur, mem[0]);
        end
        step(50);
    endtask

    task automatic test_play_drop();
        mon_en = 1'b0;
        do_tick(0);
        play = 1'b0;
        step(1);
        checks++;
        if ({note_cur, voice_active, audio_out, wrapped, bus.ram_addr} !== '0) begin
            errors++;
            $display("FAIL play_drop note=%h va=%b audio=%0d wr=%b addr=%0d exp all 0",
                     note_cur, voice_active, audio_out, wrapped, bus.ram_addr);
        end
        step(1);
        drv_addr = '0;
        play = 1'b1;
        tick = 1'b1;
        mon_en = 1'b1;
        step(1);
        tick = 1'b0;
        step(6);
        do_tick(1);
        step(20);
    endtask

    task automatic test_reset_midread();
        mon_en = 1'b0;
        do_tick(0);
        reset = 1'b1;
        step(1);
        checks++;
        if ({note_cur, voice_active, audio_out, wrapped, bus.ram_addr} !== '0) begin
            errors++;
            $display("FAIL reset_midread note=%h va=%b audio=%0d wr=%b addr=%0d exp all 0",
                     note_cur, voice_active, audio_out, wrapped, bus.ram_addr);
        end
        reset = 1'b0;
        step(1);
        drv_addr = '0;
        mon_en = 1'b1;
        do_tick(1);
        step(20);
    endtask

    initial begin
        reset = 1'b1; play = 1'b0; tick = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_single_note();
        test_fret_priority();
        test_held_note();
        test_all_open();
        test_back_to_back();
        test_wrap();
        test_play_drop();
        test_reset_midread();
        step(5);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_player.md
# note_player

Playback-side counterpart of the guitar recorder. It steps through the 64x32 note RAM one word per beat tick, decodes each string/fret word back into up to six simultaneous pitches, and synthesises a mixed square-wave audio sample stream. It sits between the recording RAM's read port and the audio codec interface, and is driven by the same beat pulse as the recorder.

## Interface
- CLK_HZ, 50_000_000, clk frequency used for the pitch table
- ADDR_W, 6, RAM address width; depth = 2^ADDR_W
- AMP, 4096, per-voice square amplitude (signed)
- ARTIC_CYCLES, 10000, mute length after each note latch (only with macro)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- play  in  1  level; 1 = playback mode
- tick  in  1  one-cycle beat pulse
- ram_addr  out  ADDR_W  RAM read address
- ram_q  in  32  RAM read data, valid one cycle after ram_addr is registered
- note_cur  out  32  currently sounding note word
- voice_active  out  6  per-string voice on
- audio_out  out  16  signed mixed sample
- wrapped  out  1  one-cycle pulse when the address wraps to 0

## Operation
- Word format: bit 6f+s = string s (0 = low E … 5 = high E) at fret f (0 = open, 1..4 = bar). Bits 31:30 are ignored. Word 0 = rest.
- Decode per string: the highest set fret wins. Semitone k = OFF[s]+f, OFF = {0,5,10,15,19,24}, so k ranges 0..28.
- Half-period table: hp(k) = round(CLK_HZ / (2·82.4069·2^(k/12))) clk cycles.
- FSM states:
  - IDLE: play=0; ram_addr=0, note_cur=0, voices off. play=1 → WAIT_TICK.
  - WAIT_TICK: tick → RD1.
  - RD1: → RD2.
  - RD2: note_cur<=ram_q; ram_addr<=ram_addr+1, wrapping 2^ADDR_W-1→0 with wrapped=1 for one cycle; → WAIT_TICK.
  - play=0 in any state → IDLE on the next edge, with all outputs cleared.
- A tick during RD1 or RD2 is ignored.
- Voice s (active when string s has any bit set):
  - Down-counter reloads with hp(k)-1 and toggles sq at 0.
  - Contribution is +AMP if sq=1, −AMP if sq=0; an inactive voice contributes 0.
- On a new latch:
  - If voice s keeps the same k, its counter and sq continue uninterrupted, so a held note does not click.
  - If k changes or the voice becomes active, the counter loads hp(k)-1 and sq=1.
- audio_out is the registered sum of the six contributions; the maximum is ±6·AMP = ±24576, with no overflow.

## Timing
- Reset values: ram_addr=0, note_cur=0, voice_active=0, audio_out=0, wrapped=0; FSM in IDLE.
- Latency:
  - tick high in cycle T → note_cur and voice_active update in cycle T+3.
  - The first audio_out reflecting the new note appears in cycle T+4.
- ram_addr is stable from the previous latch through RD2, which satisfies the RAM's registered read.
- Reset mid-read: the pending word is discarded and ram_addr returns to 0.
- play rising edge: playback always starts at address 0.
- tick in the same cycle as play rising: ignored (the FSM is still in IDLE).

## Configuration
- NOTE_PLAYER_ARTIC_EN defined: for ARTIC_CYCLES cycles starting at the cycle note_cur updates, audio_out is forced to 0 while voice counters keep running. A new latch during the mute window restarts the window.
- NOTE_PLAYER_ARTIC_EN undefined: no muting; audio_out follows the voices continuously.

## Test plan
- RAM[0]=0x0000_0002 (A string open, k=5), play=1, tick at cycle 100 → note_cur=0x2 at cycle 103; voice_active=6'b000010; audio_out toggles between +4096 and −4096 every 227,273 cycles.
- RAM[1] has bit 6·2+1 and bit 6·4+1 set (A string, frets 2 and 4) → fret 4 wins, k=9; RAM[2] = bit 6·3+2 (D string fret 3, k=13) → independent pitch.
- Held note: RAM[0]=RAM[1]=0x2, two ticks → voice 1 counter continues across the latch with no sq reset; audio_out shows no phase discontinuity.
- All six open strings (0x3F) → voice_active=6'h3F; audio_out reaches +24576 when all sq=1.
- Wrap: 64 ticks → ram_addr returns to 0, wrapped high for exactly one cycle; the 65th tick replays RAM[0].
- play dropped in RD1 → next cycle IDLE, note_cur=0, audio_out=0, ram_addr=0. With NOTE_PLAYER_ARTIC_EN, audio_out=0 for exactly 10000 cycles after each latch.
